// File: rtl/imm_encoder.sv
// Packs an immediate plus register/function fields into an RV32I instruction word.
// Two-stage valid/ready pipeline: stage 1 registers inputs and checks, stage 2 registers the word.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_imm_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [6:0]       in_funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_type_q, s1_type_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  logic [6:0]       s1_opcode_q, s1_opcode_d;
  logic [4:0]       s1_rd_q, s1_rd_d;
  logic [2:0]       s1_funct3_q, s1_funct3_d;
  logic [4:0]       s1_rs1_q, s1_rs1_d;
  logic [4:0]       s1_rs2_q, s1_rs2_d;
  logic [6:0]       s1_funct7_q, s1_funct7_d;
  logic [1:0]       s1_err_q, s1_err_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic        hi11_ok, hi12_ok, hi20_ok;
  logic [1:0]  chk_err;
  logic [31:0] inst_asm;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // An immediate fits its field when all bits above the field's sign bit copy it.
  assign hi11_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign hi12_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign hi20_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    chk_err = 2'b00;
    case (in_imm_type)
      T_R: chk_err = 2'b00;
      T_I, T_S: chk_err[0] = !hi11_ok;
      T_B: begin
        chk_err[0] = !hi12_ok;
        chk_err[1] = in_imm[0];
      end
      T_U: chk_err[1] = |in_imm[11:0];
      T_J: begin
        chk_err[0] = !hi20_ok;
        chk_err[1] = in_imm[0];
      end
      default: chk_err = 2'b11;
    endcase
  end

  // Unknown types fall back to the R layout.
  always_comb begin
    inst_asm = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
    case (s1_type_q)
      T_I: inst_asm = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      T_S: inst_asm = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                       s1_opcode_q};
      T_B: inst_asm = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                       s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      T_U: inst_asm = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      T_J: inst_asm = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q,
                       s1_opcode_q};
      default: inst_asm = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_type_d   = s1_type_q;
    s1_imm_d    = s1_imm_q;
    s1_opcode_d = s1_opcode_q;
    s1_rd_d     = s1_rd_q;
    s1_funct3_d = s1_funct3_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_funct7_d = s1_funct7_q;
    s1_err_d    = s1_err_q;
    if (in_ready) s1_valid_d = in_valid;
    if (in_fire) begin
      s1_type_d   = in_imm_type;
      s1_imm_d    = in_imm;
      s1_opcode_d = in_opcode;
      s1_rd_d     = in_rd;
      s1_funct3_d = in_funct3;
      s1_rs1_d    = in_rs1;
      s1_rs2_d    = in_rs2;
      s1_funct7_d = in_funct7;
      s1_err_d    = chk_err;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_inst_d = inst_asm;
        out_err_d  = s1_err_q;
      end
    end
    if (out_fire && (out_err_q != 2'b00) && (err_count_q != {CNT_W{1'b1}}))
      err_count_d = err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_type_q   <= '0;
      s1_imm_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_funct3_q <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct7_q <= '0;
      s1_err_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_type_q   <= s1_type_d;
      s1_imm_q    <= s1_imm_d;
      s1_opcode_q <= s1_opcode_d;
      s1_rd_q     <= s1_rd_d;
      s1_funct3_q <= s1_funct3_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_funct7_q <= s1_funct7_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a driver queues issued words, a monitor checks each
// output against a table-driven encoder, arithmetic range checks and a decode round trip.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [15:0] err_count;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_inst;
  logic [1:0]  sat_out_err;
  logic [1:0]  sat_err_count;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_imm_type(in_imm_type), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_count(err_count)
  );

  // Narrow-counter twin fed the same stream, used only for saturation.
  imm_encoder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_imm(in_imm), .in_imm_type(in_imm_type), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_inst(sat_out_inst),
    .out_err(sat_out_err), .err_count(sat_err_count)
  );

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } item_t;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    ready_mode = 0;
  int    mcnt = 0;
  int    mcnt_sat = 0;
  logic        hold = 1'b0;
  logic [31:0] h_inst;
  logic [1:0]  h_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inst bit -> immediate bit for each immediate-carrying type, -1 where a field sits.
  function automatic int imm_src(input int t, input int b);
    case (t)
      1: return (b >= 20) ? b - 20 : -1;
      2: return (b >= 25) ? b - 20 : ((b <= 11) ? b - 7 : -1);
      3: begin
        if (b == 31) return 12;
        if (b >= 25) return b - 20;
        if (b >= 8 && b <= 11) return b - 7;
        if (b == 7) return 11;
        return -1;
      end
      4: return (b >= 12) ? b : -1;
      5: begin
        if (b == 31) return 20;
        if (b >= 21) return b - 20;
        if (b == 20) return 11;
        if (b >= 12) return b;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_inst(input item_t it);
    logic [31:0] w;
    int t;
    int k;
    t = (it.typ > 3'd5) ? 0 : int'(it.typ);
    w = 32'h0;
    w[6:0] = it.op;
    if (t == 0 || t == 1 || t == 4 || t == 5) w[11:7] = it.rd;
    if (t <= 3) begin
      w[14:12] = it.f3;
      w[19:15] = it.rs1;
    end
    if (t == 0 || t == 2 || t == 3) w[24:20] = it.rs2;
    if (t == 0) w[31:25] = it.f7;
    for (int b = 7; b < 32; b++) begin
      k = imm_src(t, b);
      if (k >= 0) w[b] = it.imm[k];
    end
    return w;
  endfunction

  function automatic logic [1:0] model_err(input item_t it);
    longint s;
    logic [1:0] e;
    s = longint'($signed(it.imm));
    e = 2'b00;
    case (it.typ)
      3'd0: e = 2'b00;
      3'd1, 3'd2: e[0] = (s < -2048) || (s > 2047);
      3'd3: begin
        e[0] = (s < -4096) || (s > 4095);
        e[1] = (it.imm % 2) != 0;
      end
      3'd4: e[1] = (it.imm % 4096) != 0;
      3'd5: begin
        e[0] = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
        e[1] = (it.imm % 2) != 0;
      end
      default: e = 2'b11;
    endcase
    return e;
  endfunction

  // Core-side immediate extension, used to recover the immediate from an encoded word.
  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (t)
      3'd1: return (sx << 11) | 32'(w[30:20]);
      3'd2: return (sx << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
      3'd3: return (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd4: return w & 32'hFFFF_F000;
      3'd5: return (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic item_t mk(input int t, input logic [31:0] imm, input int op, input int rd,
                               input int f3, input int rs1, input int rs2, input int f7);
    item_t it;
    it.typ = 3'(t); it.imm = imm; it.op = 7'(op); it.rd = 5'(rd);
    it.f3 = 3'(f3); it.rs1 = 5'(rs1); it.rs2 = 5'(rs2); it.f7 = 7'(f7);
    return it;
  endfunction

  function automatic item_t rand_item(input int t, input bit legal);
    item_t it;
    int v;
    it = mk(t, $urandom, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 7),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 127));
    if (legal) begin
      case (t)
        1, 2: begin v = int'($urandom_range(0, 4095)) - 2048;     it.imm = v; end
        3:    begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; it.imm = v; end
        4:    it.imm = $urandom & 32'hFFFF_F000;
        5:    begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; it.imm = v; end
        default: ;
      endcase
    end
    return it;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = ($urandom_range(0, 7) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks stall stability and pops the scoreboard on every output transfer.
  initial begin
    item_t it;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        exp_q.delete();
        mcnt = 0;
        mcnt_sat = 0;
      end else begin
        if (hold) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_inst", out_inst, h_inst);
          chk("stall_err", 32'(out_err), 32'(h_err));
        end
        hold   = out_valid && !out_ready;
        h_inst = out_inst;
        h_err  = out_err;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_out: got inst %h with no word outstanding", out_inst);
          end else begin
            it = exp_q.pop_front();
            e  = model_err(it);
            chk("inst", out_inst, model_inst(it));
            chk("err", 32'(out_err), 32'(e));
            chk("err_count", 32'(err_count), 32'(mcnt));
            chk("sat_err_count", 32'(sat_err_count), 32'(mcnt_sat));
            if (e == 2'b00 && it.typ >= 3'd1 && it.typ <= 3'd5)
              chk("roundtrip", decode_imm(out_inst, it.typ), it.imm);
            if (e != 2'b00) begin
              if (mcnt < 65535) mcnt++;
              if (mcnt_sat < 3) mcnt_sat++;
            end
          end
        end
      end
    end
  end

  // Entered and left just after a rising edge; leaves in_valid low.
  task automatic send(input item_t it);
    int budget;
    bit done;
    budget = 0;
    done = 0;
    in_valid = 1'b1;
    in_imm_type = it.typ; in_imm = it.imm; in_opcode = it.op; in_rd = it.rd;
    in_funct3 = it.f3; in_rs1 = it.rs1; in_rs2 = it.rs2; in_funct7 = it.f7;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(it);
        done = 1;
      end else if (budget > 1000) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stuck at 0");
        done = 1;
      end
      budget++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic directed(input string name, input item_t it, input logic [31:0] inst,
                          input logic [1:0] err);
    int budget;
    send(it);
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({name, "_inst"}, out_inst, inst);
    chk({name, "_err"}, 32'(out_err), 32'(err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_imm = '0; in_imm_type = '0; in_opcode = '0; in_rd = '0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_funct7 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;

    // Latency: out_valid is low one cycle after the transfer and high the cycle after.
    send(mk(1, 32'hFFFF_FFFF, 'h13, 1, 0, 0, 0, 0));
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    chk("I_inst", out_inst, 32'hFFF0_0093);
    chk("I_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;

    directed("S", mk(2, 32'd8, 'h23, 0, 2, 1, 2, 0), 32'h0020_A423, 2'b00);
    directed("B", mk(3, 32'hFFFF_FFFC, 'h63, 0, 0, 0, 0, 0), 32'hFE00_0EE3, 2'b00);
    directed("U", mk(4, 32'h1234_5000, 'h37, 5, 0, 0, 0, 0), 32'h1234_52B7, 2'b00);
    directed("J", mk(5, 32'h0000_0800, 'h6F, 1, 0, 0, 0, 0), 32'h0010_00EF, 2'b00);

    send(mk(3, 32'd3, 'h63, 0, 0, 0, 0, 0));
    send(mk(3, 32'h1000, 'h63, 0, 0, 0, 0, 0));
    send(mk(7, 32'h0, 'h33, 3, 1, 4, 5, 'h20));
    drain();
    chk("errcnt_three", 32'(err_count), 32'd3);
    chk("sat_errcnt_three", 32'(sat_err_count), 32'd3);
    send(mk(6, 32'h0, 'h33, 0, 0, 0, 0, 0));
    drain();
    chk("errcnt_four", 32'(err_count), 32'd4);
    chk("sat_errcnt_hold", 32'(sat_err_count), 32'd3);

    // Backpressure: back-to-back words with a toggling out_ready.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(rand_item($urandom_range(0, 7), 0));
    drain();

    // Reset with both stages full.
    ready_mode = 3;
    @(posedge clk);
    #1;
    send(rand_item(1, 1));
    send(rand_item(4, 1));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    directed("post_rst_U", mk(4, 32'hABCD_E000, 'h17, 9, 0, 0, 0, 0), 32'hABCD_E497, 2'b00);

    // Randomized round trip of legal immediates per type, then fully random words.
    ready_mode = 2;
    for (int t = 1; t <= 5; t++)
      for (int i = 0; i < 3000; i++) send(rand_item(t, 1));
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) send(rand_item($urandom_range(0, 7), 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
